// File: rtl/cpu6502_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : cpu6502_pkg
// Purpose : Shared encodings for the 6502 interrupt sequencer: sequencer
//           state codes, vector addresses, bus direction and P bit indices.
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
package cpu6502_pkg;

  // Stack page and vector low-byte addresses
  localparam logic [7:0]  c_stack_page = 8'h01;
  localparam logic [15:0] c_vec_nmi    = 16'hFFFA;
  localparam logic [15:0] c_vec_rst    = 16'hFFFC;
  localparam logic [15:0] c_vec_irq    = 16'hFFFE;

  // Bus direction
  localparam logic c_rw_read  = 1'b0;
  localparam logic c_rw_write = 1'b1;

  // Status register bit positions
  localparam int c_p_bit_i = 2;
  localparam int c_p_bit_b = 4;
  localparam int c_p_bit_u = 5;

  // Sequencer state codes
  localparam logic [2:0] c_st_idle     = 3'd0;
  localparam logic [2:0] c_st_rst_wait = 3'd1;
  localparam logic [2:0] c_st_push_h   = 3'd2;
  localparam logic [2:0] c_st_push_l   = 3'd3;
  localparam logic [2:0] c_st_push_p   = 3'd4;
  localparam logic [2:0] c_st_vec_lo   = 3'd5;
  localparam logic [2:0] c_st_vec_hi   = 3'd6;
  localparam logic [2:0] c_st_load_pc  = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE     = c_st_idle,
    S_RST_WAIT = c_st_rst_wait,
    S_PUSH_H   = c_st_push_h,
    S_PUSH_L   = c_st_push_l,
    S_PUSH_P   = c_st_push_p,
    S_VEC_LO   = c_st_vec_lo,
    S_VEC_HI   = c_st_vec_hi,
    S_LOAD_PC  = c_st_load_pc
  } seq_state_t;

  // Which vector the current sequence fetches (BRK shares the IRQ vector)
  typedef enum logic [1:0] {
    VS_RST = 2'd0,
    VS_NMI = 2'd1,
    VS_IRQ = 2'd2
  } vec_sel_t;

endpackage
`default_nettype wire

// File: rtl/nmi_edge_detect.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : nmi_edge_detect
// Purpose : Falling-edge detector on the (already synchronised) NMI line with
//           a sticky pending bit. o_req also reflects an edge seen in the
//           current cycle so a boundary that coincides with the edge can
//           take the NMI immediately.
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
module nmi_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic i_nmi_n,
  input  logic i_arm,   // edges are ignored while low
  input  logic i_clr,   // NMI sequence accepted this cycle
  output logic o_req
);

  logic r_nmi_prev;
  logic r_pend;
  logic w_fall;

  assign w_fall = r_nmi_prev & ~i_nmi_n & i_arm;
  assign o_req  = r_pend | w_fall;

  // Track the previous line level; keep the request until it is consumed
  always_ff @(posedge clk) begin
    r_nmi_prev <= i_nmi_n;
    if (rst) begin
      r_pend <= 1'b0;
    end else if (i_clr) begin
      r_pend <= 1'b0;
    end else if (w_fall) begin
      r_pend <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/interrupt_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : interrupt_sequencer
// Purpose : Drives the 6502 datapath through reset, NMI, IRQ and BRK entry:
//           pushes PCH, PCL, P (interrupts only), fetches the vector and
//           loads it into PC while holding control_unit stalled via busy.
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
module interrupt_sequencer
  import cpu6502_pkg::*;
#(
  parameter logic [7:0]  STACK_PAGE = c_stack_page,
  parameter logic [15:0] VEC_NMI    = c_vec_nmi,
  parameter logic [15:0] VEC_RST    = c_vec_rst,
  parameter logic [15:0] VEC_IRQ    = c_vec_irq
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        nmi_n,
  input  logic        irq_n,
  input  logic        brk_req,
  input  logic        instr_boundary,
  input  logic        i_flag,
  input  logic [15:0] pc,
  input  logic [7:0]  p,
  input  logic [7:0]  sp,
  input  logic [7:0]  data_in,
  output logic        busy,
  output logic [15:0] addr,
  output logic [7:0]  data_out,
  output logic        read_write,
  output logic        sp_dec,
  output logic        pc_load,
  output logic [15:0] pc_value,
  output logic        set_i
);

  seq_state_t  r_state;
  vec_sel_t    r_vec_sel;
  logic        r_brk_flag;
  logic [7:0]  r_vec_lo;
  logic [7:0]  r_vec_hi;

  logic        w_nmi_req;
  logic        w_can_accept;
  logic        w_take_nmi;
  logic        w_take_brk;
  logic        w_take_irq;
  logic [15:0] w_vec_base;

  // NMI edges are not recorded while the reset sequence is waiting
  nmi_edge_detect u_nmi_edge (
    .clk     (clk),
    .rst     (rst),
    .i_nmi_n (nmi_n),
    .i_arm   (r_state != S_RST_WAIT),
    .i_clr   (w_take_nmi),
    .o_req   (w_nmi_req)
  );

  assign w_can_accept = (r_state == S_IDLE) && instr_boundary;
  assign w_take_nmi   = w_can_accept && w_nmi_req;
  assign w_take_brk   = w_can_accept && !w_nmi_req && brk_req;
  assign w_take_irq   = w_can_accept && !w_nmi_req && !brk_req && !irq_n && !i_flag;

  assign pc_value = {r_vec_hi, r_vec_lo};

  // Vector base for the sequence in flight
  always_comb begin
    case (r_vec_sel)
      VS_NMI:  w_vec_base = VEC_NMI;
      VS_IRQ:  w_vec_base = VEC_IRQ;
      default: w_vec_base = VEC_RST;
    endcase
  end

  // Sequencer state, vector selection and vector capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_RST_WAIT;
      r_vec_sel  <= VS_RST;
      r_brk_flag <= 1'b0;
      r_vec_lo   <= 8'h00;
      r_vec_hi   <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_take_nmi) begin
            r_vec_sel  <= VS_NMI;
            r_brk_flag <= 1'b0;
            r_state    <= S_PUSH_H;
          end else if (w_take_brk) begin
            r_vec_sel  <= VS_IRQ;
            r_brk_flag <= 1'b1;
            r_state    <= S_PUSH_H;
          end else if (w_take_irq) begin
            r_vec_sel  <= VS_IRQ;
            r_brk_flag <= 1'b0;
            r_state    <= S_PUSH_H;
          end
        end
        S_RST_WAIT: r_state <= S_VEC_LO;
        S_PUSH_H:   r_state <= S_PUSH_L;
        S_PUSH_L:   r_state <= S_PUSH_P;
        S_PUSH_P:   r_state <= S_VEC_LO;
        S_VEC_LO: begin
          r_vec_lo <= data_in;
          r_state  <= S_VEC_HI;
        end
        S_VEC_HI: begin
          r_vec_hi <= data_in;
          r_state  <= S_LOAD_PC;
        end
        S_LOAD_PC:  r_state <= S_IDLE;
        default:    r_state <= S_IDLE;
      endcase
    end
  end

  // Moore decode of the bus and datapath controls
  always_comb begin
    busy       = 1'b0;
    addr       = 16'h0000;
    data_out   = 8'h00;
    read_write = c_rw_read;
    sp_dec     = 1'b0;
    pc_load    = 1'b0;
    set_i      = 1'b0;
    case (r_state)
      S_RST_WAIT: busy = 1'b1;
      S_PUSH_H, S_PUSH_L, S_PUSH_P: begin
        busy       = 1'b1;
        addr       = {STACK_PAGE, sp};
        read_write = c_rw_write;
        sp_dec     = 1'b1;
        if (r_state == S_PUSH_H) begin
          data_out = pc[15:8];
        end else if (r_state == S_PUSH_L) begin
          data_out = pc[7:0];
        end else begin
          data_out            = p;
          data_out[c_p_bit_u] = 1'b1;
          data_out[c_p_bit_b] = r_brk_flag;
        end
      end
      S_VEC_LO: begin
        busy = 1'b1;
        addr = w_vec_base;
      end
      S_VEC_HI: begin
        busy = 1'b1;
        addr = w_vec_base + 16'd1;
      end
      S_LOAD_PC: begin
        busy    = 1'b1;
        pc_load = 1'b1;
        set_i   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_interrupt_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tb_interrupt_sequencer
// Purpose : Directed, table-driven bench for interrupt_sequencer. Each row is
//           one clock cycle: inputs applied for the cycle and the outputs
//           expected mid-cycle.
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_interrupt_sequencer;

  logic        clk;
  logic        rst;
  logic        nmi_n;
  logic        irq_n;
  logic        brk_req;
  logic        instr_boundary;
  logic        i_flag;
  logic [15:0] pc;
  logic [7:0]  p;
  logic [7:0]  sp;
  logic [7:0]  data_in;
  logic        busy;
  logic [15:0] addr;
  logic [7:0]  data_out;
  logic        read_write;
  logic        sp_dec;
  logic        pc_load;
  logic [15:0] pc_value;
  logic        set_i;

  int errors = 0;
  int checks = 0;

  // Expected flag groups {busy, read_write, sp_dec, pc_load, set_i}
  localparam logic [4:0] E_IDLE = 5'b00000;
  localparam logic [4:0] E_RD   = 5'b10000;
  localparam logic [4:0] E_PUSH = 5'b11100;
  localparam logic [4:0] E_LOAD = 5'b10011;

  typedef struct {
    string       nm;
    logic [5:0]  ctl;   // {rst, nmi_n, irq_n, brk_req, instr_boundary, i_flag}
    logic [15:0] pc;
    logic [7:0]  p;
    logic [7:0]  sp;
    logic [4:0]  eflags;
    logic [15:0] eaddr;
    logic [7:0]  edout;
    logic        chkpv;
    logic [15:0] epv;
  } vec_t;

  vec_t tbl[$];

  interrupt_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .nmi_n          (nmi_n),
    .irq_n          (irq_n),
    .brk_req        (brk_req),
    .instr_boundary (instr_boundary),
    .i_flag         (i_flag),
    .pc             (pc),
    .p              (p),
    .sp             (sp),
    .data_in        (data_in),
    .busy           (busy),
    .addr           (addr),
    .data_out       (data_out),
    .read_write     (read_write),
    .sp_dec         (sp_dec),
    .pc_load        (pc_load),
    .pc_value       (pc_value),
    .set_i          (set_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vector ROM: NMI=9000, RST=1234, IRQ/BRK=8000
  always_comb begin
    case (addr)
      16'hFFFA: data_in = 8'h00;
      16'hFFFB: data_in = 8'h90;
      16'hFFFC: data_in = 8'h34;
      16'hFFFD: data_in = 8'h12;
      16'hFFFE: data_in = 8'h00;
      16'hFFFF: data_in = 8'h80;
      default:  data_in = 8'hEE;
    endcase
  end

  function automatic vec_t mk(input string nm, input logic [5:0] ctl,
                              input logic [15:0] pc_i, input logic [7:0] p_i,
                              input logic [7:0] sp_i, input logic [4:0] ef,
                              input logic [15:0] ea, input logic [7:0] ed,
                              input logic chk, input logic [15:0] epv);
    vec_t v;
    v.nm = nm; v.ctl = ctl; v.pc = pc_i; v.p = p_i; v.sp = sp_i;
    v.eflags = ef; v.eaddr = ea; v.edout = ed; v.chkpv = chk; v.epv = epv;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    logic [4:0] got;
    {rst, nmi_n, irq_n, brk_req, instr_boundary, i_flag} = v.ctl;
    pc = v.pc;
    p  = v.p;
    sp = v.sp;
    @(negedge clk);
    got = {busy, read_write, sp_dec, pc_load, set_i};
    checks++;
    if (got !== v.eflags || addr !== v.eaddr || data_out !== v.edout ||
        (v.chkpv && pc_value !== v.epv)) begin
      errors++;
      $display("FAIL %s: got flags=%b addr=%h dout=%h pcv=%h, expected flags=%b addr=%h dout=%h pcv=%h",
               v.nm, got, addr, data_out, pc_value, v.eflags, v.eaddr, v.edout, v.epv);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset sequence: 4 busy cycles after rst drops
    tbl.push_back(mk("rst_hold",   6'b111001, 16'h0000, 8'h00, 8'hFD, E_RD,   16'h0000, 8'h00, 1'b0, 16'h0000));
    tbl.push_back(mk("rst_wait",   6'b011001, 16'h0000, 8'h00, 8'hFD, E_RD,   16'h0000, 8'h00, 1'b0, 16'h0000));
    tbl.push_back(mk("rst_vlo",    6'b011001, 16'h0000, 8'h00, 8'hFD, E_RD,   16'hFFFC, 8'h00, 1'b0, 16'h0000));
    tbl.push_back(mk("rst_vhi",    6'b011001, 16'h0000, 8'h00, 8'hFD, E_RD,   16'hFFFD, 8'h00, 1'b0, 16'h0000));
    tbl.push_back(mk("rst_load",   6'b011001, 16'h0000, 8'h00, 8'hFD, E_LOAD, 16'h0000, 8'h00, 1'b1, 16'h1234));
    // Masked IRQ at a boundary is ignored
    tbl.push_back(mk("irq_masked", 6'b010011, 16'h1234, 8'h04, 8'hFD, E_IDLE, 16'h0000, 8'h00, 1'b0, 16'h0000));
    // BRK at 0302, sp=FD, p=00
    tbl.push_back(mk("brk_acc",    6'b011110, 16'h0302, 8'h00, 8'hFD, E_IDLE, 16'h0000, 8'h00, 1'b0, 16'h0000));
    tbl.push_back(mk("brk_ph",     6'b011000, 16'h0302, 8'h00, 8'hFD, E_PUSH, 16'h01FD, 8'h03, 1'b0, 16'h0000));
    tbl.push_back(mk("brk_pl",     6'b011000, 16'h0302, 8'h00, 8'hFC, E_PUSH, 16'h01FC, 8'h02, 1'b0, 16'h0000));
    tbl.push_back(mk("brk_pp",     6'b011000, 16'h0302, 8'h00, 8'hFB, E_PUSH, 16'h01FB, 8'h30, 1'b0, 16'h0000));
    tbl.push_back(mk("brk_vlo",    6'b011000, 16'h0302, 8'h00, 8'hFA, E_RD,   16'hFFFE, 8'h00, 1'b0, 16'h0000));
    tbl.push_back(mk("brk_vhi",    6'b011000, 16'h0302, 8'h00, 8'hFA, E_RD,   16'hFFFF, 8'h00, 1'b0, 16'h0000));
    tbl.push_back(mk("brk_load",   6'b011000, 16'h0302, 8'h00, 8'hFA, E_LOAD, 16'h0000, 8'h00, 1'b1, 16'h8000));
    // IRQ masked, then taken; NMI edge arrives during PUSH_H
    tbl.push_back(mk("irq_msk2",   6'b010011, 16'h8000, 8'hC3, 8'hFA, E_IDLE, 16'h0000, 8'h00, 1'b0, 16'h0000));
    tbl.push_back(mk("irq_acc",    6'b010010, 16'h8000, 8'hC3, 8'hFA, E_IDLE, 16'h0000, 8'h00, 1'b0, 16'h0000));
    tbl.push_back(mk("irq_ph_nmi", 6'b000000, 16'h8000, 8'hC3, 8'hFA, E_PUSH, 16'h01FA, 8'h80, 1'b0, 16'h0000));
    tbl.push_back(mk("irq_pl",     6'b000000, 16'h8000, 8'hC3, 8'hF9, E_PUSH, 16'h01F9, 8'h00, 1'b0, 16'h0000));
    tbl.push_back(mk("irq_pp",     6'b000000, 16'h8000, 8'hC3, 8'hF8, E_PUSH, 16'h01F8, 8'hE3, 1'b0, 16'h0000));
    tbl.push_back(mk("irq_vlo",    6'b000000, 16'h8000, 8'hC3, 8'hF7, E_RD,   16'hFFFE, 8'h00, 1'b0, 16'h0000));
    tbl.push_back(mk("irq_vhi",    6'b000000, 16'h8000, 8'hC3, 8'hF7, E_RD,   16'hFFFF, 8'h00, 1'b0, 16'h0000));
    tbl.push_back(mk("irq_load",   6'b000000, 16'h8000, 8'hC3, 8'hF7, E_LOAD, 16'h0000, 8'h00, 1'b1, 16'h8000));
    // Pending NMI waits for a boundary, then runs
    tbl.push_back(mk("nmi_wait",   6'b001001, 16'h8000, 8'h04, 8'hF7, E_IDLE, 16'h0000, 8'h00, 1'b0, 16'h0000));
    tbl.push_back(mk("nmi_acc",    6'b001011, 16'h8000, 8'h04, 8'hF7, E_IDLE, 16'h0000, 8'h00, 1'b0, 16'h0000));
    tbl.push_back(mk("nmi_ph",     6'b001001, 16'h8000, 8'h04, 8'hF7, E_PUSH, 16'h01F7, 8'h80, 1'b0, 16'h0000));
    tbl.push_back(mk("nmi_pl",     6'b001001, 16'h8000, 8'h04, 8'hF6, E_PUSH, 16'h01F6, 8'h00, 1'b0, 16'h0000));
    tbl.push_back(mk("nmi_pp",     6'b001001, 16'h8000, 8'h04, 8'hF5, E_PUSH, 16'h01F5, 8'h24, 1'b0, 16'h0000));
    tbl.push_back(mk("nmi_vlo",    6'b001001, 16'h8000, 8'h04, 8'hF4, E_RD,   16'hFFFA, 8'h00, 1'b0, 16'h0000));
    tbl.push_back(mk("nmi_vhi",    6'b001001, 16'h8000, 8'h04, 8'hF4, E_RD,   16'hFFFB, 8'h00, 1'b0, 16'h0000));
    tbl.push_back(mk("nmi_load",   6'b001001, 16'h8000, 8'h04, 8'hF4, E_LOAD, 16'h0000, 8'h00, 1'b1, 16'h9000));
    // Level-low NMI with no new edge must not retrigger
    tbl.push_back(mk("nmi_clear",  6'b001010, 16'h9000, 8'h00, 8'hF4, E_IDLE, 16'h0000, 8'h00, 1'b0, 16'h0000));
    // NMI edge and IRQ at the same boundary: NMI first
    tbl.push_back(mk("nmi_rise",   6'b010001, 16'h9000, 8'h00, 8'hF4, E_IDLE, 16'h0000, 8'h00, 1'b0, 16'h0000));
    tbl.push_back(mk("both_acc",   6'b000010, 16'h9000, 8'h00, 8'hF4, E_IDLE, 16'h0000, 8'h00, 1'b0, 16'h0000));
    tbl.push_back(mk("both_ph",    6'b010000, 16'h9000, 8'h00, 8'hF4, E_PUSH, 16'h01F4, 8'h90, 1'b0, 16'h0000));
    tbl.push_back(mk("both_pl",    6'b010000, 16'h9000, 8'h00, 8'hF3, E_PUSH, 16'h01F3, 8'h00, 1'b0, 16'h0000));
    tbl.push_back(mk("both_pp",    6'b010000, 16'h9000, 8'h00, 8'hF2, E_PUSH, 16'h01F2, 8'h20, 1'b0, 16'h0000));
    tbl.push_back(mk("both_vlo",   6'b010000, 16'h9000, 8'h00, 8'hF1, E_RD,   16'hFFFA, 8'h00, 1'b0, 16'h0000));
    tbl.push_back(mk("both_vhi",   6'b010000, 16'h9000, 8'h00, 8'hF1, E_RD,   16'hFFFB, 8'h00, 1'b0, 16'h0000));
    tbl.push_back(mk("both_load",  6'b010000, 16'h9000, 8'h00, 8'hF1, E_LOAD, 16'h0000, 8'h00, 1'b1, 16'h9000));
    tbl.push_back(mk("irq_msk3",   6'b010011, 16'h9000, 8'h01, 8'hF1, E_IDLE, 16'h0000, 8'h00, 1'b0, 16'h0000));
    tbl.push_back(mk("irq2_acc",   6'b010010, 16'h9000, 8'h01, 8'hF1, E_IDLE, 16'h0000, 8'h00, 1'b0, 16'h0000));
    tbl.push_back(mk("irq2_ph",    6'b010000, 16'h9000, 8'h01, 8'hF1, E_PUSH, 16'h01F1, 8'h90, 1'b0, 16'h0000));
    tbl.push_back(mk("irq2_pl",    6'b010000, 16'h9000, 8'h01, 8'hF0, E_PUSH, 16'h01F0, 8'h00, 1'b0, 16'h0000));
    tbl.push_back(mk("irq2_pp",    6'b010000, 16'h9000, 8'h01, 8'hEF, E_PUSH, 16'h01EF, 8'h21, 1'b0, 16'h0000));
    tbl.push_back(mk("irq2_vlo",   6'b010000, 16'h9000, 8'h01, 8'hEE, E_RD,   16'hFFFE, 8'h00, 1'b0, 16'h0000));
    tbl.push_back(mk("irq2_vhi",   6'b010000, 16'h9000, 8'h01, 8'hEE, E_RD,   16'hFFFF, 8'h00, 1'b0, 16'h0000));
    tbl.push_back(mk("irq2_load",  6'b010000, 16'h9000, 8'h01, 8'hEE, E_LOAD, 16'h0000, 8'h00, 1'b1, 16'h8000));

    // Hold reset across one edge so the first row starts in RST_WAIT
    {rst, nmi_n, irq_n, brk_req, instr_boundary, i_flag} = 6'b111001;
    pc = 16'h0000; p = 8'h00; sp = 8'hFD;
    @(posedge clk);
    #1;

    foreach (tbl[i]) apply(tbl[i]);

    // Stack wrap at sp=00, NMI edge in PUSH_H, reset during PUSH_L
    apply(mk("wrap_acc",  6'b011110, 16'h0302, 8'h00, 8'h00, E_IDLE, 16'h0000, 8'h00, 1'b0, 16'h0000));
    apply(mk("wrap_ph",   6'b001000, 16'h0302, 8'h00, 8'h00, E_PUSH, 16'h0100, 8'h03, 1'b0, 16'h0000));
    apply(mk("rst_in_pl", 6'b101000, 16'h0302, 8'h00, 8'hFF, E_PUSH, 16'h01FF, 8'h02, 1'b0, 16'h0000));
    apply(mk("post_rst",  6'b001000, 16'h0302, 8'h00, 8'hFE, E_RD,   16'h0000, 8'h00, 1'b1, 16'h0000));
    apply(mk("prst_vlo",  6'b001000, 16'h0302, 8'h00, 8'hFE, E_RD,   16'hFFFC, 8'h00, 1'b0, 16'h0000));
    apply(mk("prst_vhi",  6'b001000, 16'h0302, 8'h00, 8'hFE, E_RD,   16'hFFFD, 8'h00, 1'b0, 16'h0000));
    apply(mk("prst_load", 6'b001000, 16'h0302, 8'h00, 8'hFE, E_LOAD, 16'h0000, 8'h00, 1'b1, 16'h1234));
    // The NMI edge taken before reset must have been discarded
    apply(mk("pend_gone1", 6'b001010, 16'h1234, 8'h04, 8'hFE, E_IDLE, 16'h0000, 8'h00, 1'b0, 16'h0000));
    apply(mk("pend_gone2", 6'b001010, 16'h1234, 8'h04, 8'hFE, E_IDLE, 16'h0000, 8'h00, 1'b0, 16'h0000));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
